// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// The master drives the commands and the slave (the timer) returns its state.
interface countdown_timer_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] value;
   logic             en;
   logic             reload;
   logic             clear;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output load, value, en, reload, clear,
      input  count, busy, done
   );

   modport slave (
      input  load, value, en, reload, clear,
      output count, busy, done
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle EXPIRE state and optional auto-reload.
// busy and done are registered alongside the state, so inputs never reach them combinationally.
module countdown_timer #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   countdown_timer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] rld_q;
   logic             busy_q;
   logic             done_q;

   assign bus.count = count_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         count_q <= '0;
         rld_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.clear) begin
         state   <= IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.load) begin
         state   <= RUN;
         count_q <= bus.value;
         rld_q   <= bus.value;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
            RUN: begin
               // A zero count expires without needing en; otherwise en gates the decrement.
               if (count_q == '0) begin
                  state  <= EXPIRE;
                  done_q <= 1'b1;
               end else if (bus.en) begin
                  count_q <= count_q - ONE;
                  if (count_q == ONE) begin
                     state  <= EXPIRE;
                     done_q <= 1'b1;
                  end
               end
            end
            EXPIRE: begin
               done_q <= 1'b0;
               if (bus.reload) begin
                  state   <= RUN;
                  count_q <= rld_q;
               end else begin
                  state   <= IDLE;
                  count_q <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               count_q <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a driver predicts each edge from the timer rules,
// and a monitor compares the DUT after every rising edge.
module tb_countdown_timer;
   localparam int W = 8;

   logic clk;
   logic rst;
   countdown_timer_if #(.WIDTH(W)) bus ();

   countdown_timer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   cnt;
      logic busy;
      logic done;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   errors  = 0;

   // Reference: a timer is either idle, counting, or sitting in its one-cycle expiry.
   int   m_cnt = 0;
   int   m_rld = 0;
   bit   m_active = 0;
   bit   m_expiring = 0;
   int   max_val = (1 << W) - 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_rld = 0; m_active = 0; m_expiring = 0;
   endtask

   task automatic model_step(input bit r, input bit ld, input int v, input bit e,
                             input bit rl, input bit clr);
      if (!r) model_reset();
      else if (clr) begin
         m_cnt = 0; m_active = 0; m_expiring = 0;
      end else if (ld) begin
         m_cnt = v; m_rld = v; m_active = 1; m_expiring = 0;
      end else if (m_expiring) begin
         m_expiring = 0;
         if (rl) m_cnt = m_rld;
         else begin
            m_active = 0; m_cnt = 0;
         end
      end else if (m_active) begin
         if (m_cnt == 0) m_expiring = 1;
         else if (e) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_expiring = 1;
         end
      end
   endtask

   // One rising edge: apply inputs after the falling edge and queue the predicted result.
   task automatic drive(input bit r, input bit ld, input int v, input bit e,
                        input bit rl, input bit clr);
      exp_t x;
      @(negedge clk);
      rst        = r;
      bus.load   = ld;
      bus.value  = W'(v);
      bus.en     = e;
      bus.reload = rl;
      bus.clear  = clr;
      model_step(r, ld, v, e, rl, clr);
      x.cnt  = m_cnt;
      x.busy = m_active;
      x.done = m_expiring;
      exp_q.push_back(x);
   endtask

   task automatic idle(input int n, input bit e, input bit rl);
      for (int i = 0; i < n; i++) drive(1, 0, 0, e, rl, 0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("count", 32'(bus.count), 32'(x.cnt));
            check("busy", 32'(bus.busy), 32'(x.busy));
            check("done", 32'(bus.done), 32'(x.done));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b0;
      bus.load = 0; bus.value = '0; bus.en = 0; bus.reload = 0; bus.clear = 0;
      #2;
      check("reset_count", 32'(bus.count), 0);
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_done", 32'(bus.done), 0);
      drive(0, 1, 9, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 0);

      // basic countdown
      drive(1, 1, 3, 0, 0, 0);
      idle(6, 1, 0);
      // enable gaps
      drive(1, 1, 3, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 1, 0, 0);
      idle(2, 0, 0);
      // auto-reload, then zero-value reload ping-pong
      drive(1, 1, 2, 1, 1, 0);
      idle(7, 1, 1);
      drive(1, 1, 0, 0, 1, 0);
      idle(5, 0, 1);
      drive(1, 0, 0, 0, 0, 1);
      // zero load expires without en
      drive(1, 1, 0, 0, 0, 0);
      idle(3, 0, 0);
      // clear beats a simultaneous load
      drive(1, 1, 5, 0, 0, 0);
      idle(2, 1, 0);
      drive(1, 1, 7, 1, 0, 1);
      idle(2, 1, 0);
      // restart while expiring
      drive(1, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0);
      drive(1, 1, 4, 1, 0, 0);
      idle(6, 1, 0);

      // async reset between edges with count at 2
      drive(1, 1, 5, 0, 0, 0);
      idle(3, 1, 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      bus.en = 0;
      model_reset();
      #1;
      check("async_count", 32'(bus.count), 0);
      check("async_busy", 32'(bus.busy), 0);
      check("async_done", 32'(bus.done), 0);
      drive(0, 0, 0, 1, 0, 0);
      idle(3, 1, 0);
      // all-ones load must reach zero without wrapping
      drive(1, 1, max_val, 1, 0, 0);
      idle(max_val + 4, 1, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         int v;
         v = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, max_val))
                                         : int'($urandom_range(0, 6));
         drive(1,
               $urandom_range(0, 9) == 0,
               v,
               $urandom_range(0, 9) < 7,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 24) == 0);
      end

      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
